// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write arbiter.
package fifo_arb_pkg;

  localparam int unsigned GRANT_W = 3;
  localparam int unsigned MAX_REQ = 8;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester bus and downstream FIFO write port of the FIFO write arbiter.
interface fifo_wr_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REQ    = 4
);
  import fifo_arb_pkg::*;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic [DATA_WIDTH-1:0]         fifo_din;
  logic                          fifo_wr_en;
  logic                          fifo_full;
  logic [GRANT_W-1:0]            grant_idx;
  logic                          busy;
  logic                          timeout_err;

  modport master (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_din, fifo_wr_en, grant_idx, busy, timeout_err
  );

  modport slave (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_din, fifo_wr_en, grant_idx, busy, timeout_err
  );

endinterface

// File: rtl/rr_picker.sv
// Round-robin winner search starting just above last_grant, wrapping to 0.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GRANT_W-1:0] last_grant,
  output logic [GRANT_W-1:0] winner,
  output logic               any_req
);

  logic [MAX_REQ-1:0] req_ext;
  logic [GRANT_W-1:0] idx;

  assign req_ext = MAX_REQ'(req);
  assign any_req = |req;

  // Walk offsets from farthest to nearest so the nearest valid requester wins.
  always_comb begin
    winner = '0;
    idx    = '0;
    for (int k = int'(NUM_REQ); k > 0; k--) begin
      idx = GRANT_W'((int'(last_grant) + k) % int'(NUM_REQ));
      if (req_ext[idx]) winner = idx;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-granular round-robin arbiter feeding one downstream FIFO write port.
// FIFO_WR_ARBITER_TIMEOUT_EN adds a stall watchdog that revokes a silent grant.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst,
  fifo_wr_arbiter_if.slave  bus
);

  state_e             state_q, state_d;
  logic [GRANT_W-1:0] grant_q, grant_d;
  logic [GRANT_W-1:0] last_q, last_d;
  logic [GRANT_W-1:0] pick_idx;
  logic               pick_any;
  logic [MAX_REQ-1:0] valid_ext, last_ext;
  logic [DATA_WIDTH-1:0] data_arr [MAX_REQ];
  logic               xfer, sel_valid, sel_last, accept;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req        (bus.req_valid),
    .last_grant (last_q),
    .winner     (pick_idx),
    .any_req    (pick_any)
  );

  // Pad the requester vectors to the full index range of grant_q.
  assign valid_ext = MAX_REQ'(bus.req_valid);
  assign last_ext  = MAX_REQ'(bus.req_last);

  for (genvar i = 0; i < int'(MAX_REQ); i++) begin : g_slot
    if (i < int'(NUM_REQ)) begin : g_real
      assign data_arr[i]      = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      assign bus.req_ready[i] = xfer && !bus.fifo_full && (grant_q == GRANT_W'(i));
    end else begin : g_pad
      assign data_arr[i] = '0;
    end
  end

  assign xfer      = (state_q == XFER);
  assign sel_valid = valid_ext[grant_q];
  assign sel_last  = last_ext[grant_q];
  assign accept    = xfer && sel_valid && !bus.fifo_full;

  assign bus.fifo_wr_en = accept;
  assign bus.fifo_din   = xfer ? data_arr[grant_q] : '0;
  assign bus.grant_idx  = grant_q;
  assign bus.busy       = xfer;

`ifdef FIFO_WR_ARBITER_TIMEOUT_EN
  localparam int unsigned WD_W = 16;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;
  assign bus.timeout_err = timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout  = ^16'(TIMEOUT_CYCLES);
  assign bus.timeout_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
`ifdef FIFO_WR_ARBITER_TIMEOUT_EN
    wd_d      = wd_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = XFER;
        end
`ifdef FIFO_WR_ARBITER_TIMEOUT_EN
        wd_d = '0;
`endif
      end
      XFER: begin
        if (accept && sel_last) begin
          state_d = IDLE;
          last_d  = grant_q;
        end
`ifdef FIFO_WR_ARBITER_TIMEOUT_EN
        // Backpressure from the FIFO is not the requester's fault: hold the count.
        if (accept) begin
          wd_d = '0;
        end else if (!bus.fifo_full) begin
          if (wd_q + 1'b1 >= WD_W'(TIMEOUT_CYCLES)) begin
            state_d   = IDLE;
            last_d    = grant_q;
            timeout_d = 1'b1;
            wd_d      = '0;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GRANT_W'(NUM_REQ - 1);
`ifdef FIFO_WR_ARBITER_TIMEOUT_EN
      wd_q      <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
`ifdef FIFO_WR_ARBITER_TIMEOUT_EN
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (4 requesters, 8-bit data, TIMEOUT_CYCLES=4).
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned NR = 4;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bif ();

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    bif.req_valid = '0;
    bif.req_data  = '0;
    bif.req_last  = '0;
    bif.fifo_full = 1'b0;
  endtask

  task automatic set_word(input int i, input logic [DW-1:0] d, input logic l);
    bif.req_data[i*DW +: DW] = d;
    bif.req_last[i]          = l;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    vectors++; if (bif.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bif.busy); end
    vectors++; if (bif.grant_idx !== 3'd0) begin miscompares++; $display("FAIL reset_grant: got %0d want 0", bif.grant_idx); end
    vectors++; if (bif.timeout_err !== 1'b0) begin miscompares++; $display("FAIL reset_timeout: got %b want 0", bif.timeout_err); end
    vectors++; if (bif.fifo_wr_en !== 1'b0) begin miscompares++; $display("FAIL reset_wr_en: got %b want 0", bif.fifo_wr_en); end
    vectors++; if (bif.req_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_ready: got %b want 0000", bif.req_ready); end
  endtask

  task automatic test_basic();
    logic [DW-1:0] w [3];
    w = '{8'hA1, 8'hA2, 8'hA3};
    @(negedge clk);
    bif.req_valid = 4'b0100;
    set_word(2, w[0], 1'b0);
    #1;
    vectors++; if (bif.busy !== 1'b0) begin miscompares++; $display("FAIL basic_idle_busy: got %b want 0", bif.busy); end
    vectors++; if (bif.fifo_wr_en !== 1'b0) begin miscompares++; $display("FAIL basic_idle_wr_en: got %b want 0", bif.fifo_wr_en); end
    vectors++; if (bif.req_ready !== 4'b0000) begin miscompares++; $display("FAIL basic_idle_ready: got %b want 0000", bif.req_ready); end
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      set_word(2, w[b], b == 2);
      #1;
      vectors++; if (bif.grant_idx !== 3'd2) begin miscompares++; $display("FAIL basic_grant[%0d]: got %0d want 2", b, bif.grant_idx); end
      vectors++; if (bif.fifo_wr_en !== 1'b1) begin miscompares++; $display("FAIL basic_wr_en[%0d]: got %b want 1", b, bif.fifo_wr_en); end
      vectors++; if (bif.fifo_din !== w[b]) begin miscompares++; $display("FAIL basic_din[%0d]: got %h want %h", b, bif.fifo_din, w[b]); end
      vectors++; if (bif.req_ready !== 4'b0100) begin miscompares++; $display("FAIL basic_ready[%0d]: got %b want 0100", b, bif.req_ready); end
    end
    @(negedge clk);
    clear_inputs();
    #1;
    vectors++; if (bif.busy !== 1'b0) begin miscompares++; $display("FAIL basic_end_busy: got %b want 0", bif.busy); end
    vectors++; if (bif.fifo_wr_en !== 1'b0) begin miscompares++; $display("FAIL basic_end_wr_en: got %b want 0", bif.fifo_wr_en); end
  endtask

  task automatic test_rotation();
    logic [2:0] eg;
    logic [DW-1:0] ed;
    do_reset();
    for (int p = 0; p < 8; p++) begin
      @(negedge clk);
      if (p == 0) begin
        bif.req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) set_word(i, 8'(8'h10 + i), 1'b1);
      end
      #1;
      vectors++; if (bif.busy !== 1'b0 || bif.fifo_wr_en !== 1'b0) begin miscompares++; $display("FAIL rot_idle[%0d]: got busy=%b wr_en=%b want 0 0", p, bif.busy, bif.fifo_wr_en); end
      @(negedge clk);
      #1;
      eg = 3'(p % 4);
      ed = 8'(8'h10 + (p % 4));
      vectors++; if (bif.grant_idx !== eg || bif.busy !== 1'b1) begin miscompares++; $display("FAIL rot_grant[%0d]: got %0d busy=%b want %0d busy=1", p, bif.grant_idx, bif.busy, eg); end
      vectors++; if (bif.fifo_wr_en !== 1'b1 || bif.fifo_din !== ed) begin miscompares++; $display("FAIL rot_din[%0d]: got wr_en=%b din=%h want 1 %h", p, bif.fifo_wr_en, bif.fifo_din, ed); end
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_full_stall();
    logic [DW-1:0] words [3];
    logic [DW-1:0] log_q [$];
    int ptr;
    words = '{8'hB1, 8'hB2, 8'hB3};
    ptr = 0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bif.req_valid = (ptr < 3) ? 4'b0001 : 4'b0000;
      if (ptr < 3) set_word(0, words[ptr], ptr == 2);
      bif.fifo_full = (c >= 2 && c <= 6);
      #1;
      if (c >= 2 && c <= 6) begin
        vectors++; if (bif.req_ready !== 4'b0000) begin miscompares++; $display("FAIL stall_ready[c%0d]: got %b want 0000", c, bif.req_ready); end
        vectors++; if (bif.fifo_wr_en !== 1'b0) begin miscompares++; $display("FAIL stall_wr_en[c%0d]: got %b want 0", c, bif.fifo_wr_en); end
      end
      if (bif.fifo_wr_en === 1'b1) log_q.push_back(bif.fifo_din);
      if (bif.req_valid[0] && bif.req_ready[0] === 1'b1) ptr++;
    end
    vectors++; if (log_q.size() != 3) begin miscompares++; $display("FAIL stall_count: got %0d words want 3", log_q.size()); end
    for (int i = 0; i < 3 && i < log_q.size(); i++) begin
      vectors++; if (log_q[i] !== words[i]) begin miscompares++; $display("FAIL stall_word[%0d]: got %h want %h", i, log_q[i], words[i]); end
    end
    vectors++; if (bif.busy !== 1'b0) begin miscompares++; $display("FAIL stall_end_busy: got %b want 0", bif.busy); end
    clear_inputs();
  endtask

  task automatic test_hold();
    logic [DW-1:0] w [3];
    w = '{8'hC1, 8'hC2, 8'hC3};
    do_reset();
    @(negedge clk);
    bif.req_valid = 4'b0010;
    set_word(1, w[0], 1'b0);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      bif.req_valid = 4'b1010;
      set_word(3, 8'hD1, 1'b1);
      set_word(1, w[b], b == 2);
      #1;
      vectors++; if (bif.grant_idx !== 3'd1) begin miscompares++; $display("FAIL hold_grant[%0d]: got %0d want 1", b, bif.grant_idx); end
      vectors++; if (bif.fifo_din !== w[b] || bif.fifo_wr_en !== 1'b1) begin miscompares++; $display("FAIL hold_din[%0d]: got %h wr_en=%b want %h 1", b, bif.fifo_din, bif.fifo_wr_en, w[b]); end
      vectors++; if (bif.req_ready !== 4'b0010) begin miscompares++; $display("FAIL hold_ready[%0d]: got %b want 0010", b, bif.req_ready); end
    end
    @(negedge clk);
    bif.req_valid = 4'b1000;
    #1;
    vectors++; if (bif.busy !== 1'b0) begin miscompares++; $display("FAIL hold_gap_busy: got %b want 0", bif.busy); end
    @(negedge clk);
    #1;
    vectors++; if (bif.grant_idx !== 3'd3 || bif.busy !== 1'b1) begin miscompares++; $display("FAIL hold_next_grant: got %0d busy=%b want 3 busy=1", bif.grant_idx, bif.busy); end
    vectors++; if (bif.fifo_din !== 8'hD1 || bif.fifo_wr_en !== 1'b1) begin miscompares++; $display("FAIL hold_next_din: got %h wr_en=%b want d1 1", bif.fifo_din, bif.fifo_wr_en); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_watchdog();
    do_reset();
    @(negedge clk);
    bif.req_valid = 4'b0101;
    set_word(0, 8'hE1, 1'b0);
    set_word(2, 8'hF1, 1'b1);
    @(negedge clk);
    #1;
    vectors++; if (bif.grant_idx !== 3'd0 || bif.fifo_din !== 8'hE1 || bif.fifo_wr_en !== 1'b1) begin miscompares++; $display("FAIL wd_first: got grant=%0d din=%h wr_en=%b want 0 e1 1", bif.grant_idx, bif.fifo_din, bif.fifo_wr_en); end
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      bif.req_valid = 4'b0100;
      #1;
      vectors++; if (bif.busy !== 1'b1 || bif.grant_idx !== 3'd0 || bif.fifo_wr_en !== 1'b0) begin miscompares++; $display("FAIL wd_stall[%0d]: got busy=%b grant=%0d wr_en=%b want 1 0 0", s, bif.busy, bif.grant_idx, bif.fifo_wr_en); end
      vectors++; if (bif.timeout_err !== 1'b0) begin miscompares++; $display("FAIL wd_stall_to[%0d]: got %b want 0", s, bif.timeout_err); end
    end
`ifdef FIFO_WR_ARBITER_TIMEOUT_EN
    @(negedge clk);
    #1;
    vectors++; if (bif.timeout_err !== 1'b1 || bif.busy !== 1'b0) begin miscompares++; $display("FAIL wd_fire: got to=%b busy=%b want 1 0", bif.timeout_err, bif.busy); end
    @(negedge clk);
    #1;
    vectors++; if (bif.timeout_err !== 1'b0) begin miscompares++; $display("FAIL wd_pulse: got %b want 0", bif.timeout_err); end
    vectors++; if (bif.grant_idx !== 3'd2 || bif.fifo_din !== 8'hF1 || bif.fifo_wr_en !== 1'b1) begin miscompares++; $display("FAIL wd_next: got grant=%0d din=%h wr_en=%b want 2 f1 1", bif.grant_idx, bif.fifo_din, bif.fifo_wr_en); end
`else
    for (int s = 0; s < 8; s++) begin
      @(negedge clk);
      #1;
      vectors++; if (bif.busy !== 1'b1 || bif.grant_idx !== 3'd0 || bif.timeout_err !== 1'b0) begin miscompares++; $display("FAIL wd_hold[%0d]: got busy=%b grant=%0d to=%b want 1 0 0", s, bif.busy, bif.grant_idx, bif.timeout_err); end
      vectors++; if (bif.req_ready !== 4'b0001) begin miscompares++; $display("FAIL wd_hold_ready[%0d]: got %b want 0001", s, bif.req_ready); end
    end
    @(negedge clk);
    bif.req_valid = 4'b0101;
    set_word(0, 8'hE2, 1'b1);
    #1;
    vectors++; if (bif.fifo_din !== 8'hE2 || bif.fifo_wr_en !== 1'b1) begin miscompares++; $display("FAIL wd_resume: got din=%h wr_en=%b want e2 1", bif.fifo_din, bif.fifo_wr_en); end
    @(negedge clk);
    bif.req_valid = 4'b0100;
    #1;
    vectors++; if (bif.busy !== 1'b0) begin miscompares++; $display("FAIL wd_resume_idle: got %b want 0", bif.busy); end
    @(negedge clk);
    #1;
    vectors++; if (bif.grant_idx !== 3'd2 || bif.fifo_din !== 8'hF1) begin miscompares++; $display("FAIL wd_resume_next: got grant=%0d din=%h want 2 f1", bif.grant_idx, bif.fifo_din); end
`endif
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    bif.req_valid = 4'b0001;
    set_word(0, 8'h61, 1'b0);
    @(negedge clk);
    #1;
    vectors++; if (bif.fifo_din !== 8'h61 || bif.fifo_wr_en !== 1'b1) begin miscompares++; $display("FAIL rmid_first: got din=%h wr_en=%b want 61 1", bif.fifo_din, bif.fifo_wr_en); end
    @(negedge clk);
    bif.req_valid = 4'b0011;
    set_word(0, 8'h62, 1'b0);
    set_word(1, 8'h71, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++; if (bif.busy !== 1'b0 || bif.fifo_wr_en !== 1'b0) begin miscompares++; $display("FAIL rmid_after: got busy=%b wr_en=%b want 0 0", bif.busy, bif.fifo_wr_en); end
    vectors++; if (bif.timeout_err !== 1'b0) begin miscompares++; $display("FAIL rmid_timeout: got %b want 0", bif.timeout_err); end
    @(negedge clk);
    #1;
    vectors++; if (bif.busy !== 1'b1 || bif.grant_idx !== 3'd0) begin miscompares++; $display("FAIL rmid_regrant: got busy=%b grant=%0d want 1 0", bif.busy, bif.grant_idx); end
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL tb_timeout: simulation did not finish, want completion");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_basic();
    test_rotation();
    test_full_stall();
    test_hold();
    test_watchdog();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
